// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register.
// Aligns and extends load data, selects the write-back source and registers the result,
// so wb_data_o can drive the register-file write port directly. Also provides an EX
// forwarding tap and a retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,             // datapath width, 32 or 64
  parameter int unsigned REG_AW = 5,              // register-address width
  parameter int unsigned CNT_W  = 32,             // retired counter width
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic [1:0]        load_size_i,
  input  logic              load_unsigned_i,
  input  logic [OFF_W-1:0]  byte_off_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              reg_write_o,
  output logic              fwd_en_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam int DW = int'(DATA_W);

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzFull = 2'b11
  } load_size_e;

  load_size_e        load_size;
  logic [OFF_W-1:0]  eff_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic              fill;
  logic [DATA_W-1:0] wb_data_d;
  logic              reg_write_d;
  logic              rd_nonzero;

  logic              valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_write_q;
  logic [CNT_W-1:0]  retired_q;

  assign load_size = load_size_e'(load_size_i);

  // Effective byte offset: sub-field alignment bits are ignored, full-width loads ignore it.
  always_comb begin
    eff_off = byte_off_i;
    case (load_size)
      SzByte:  eff_off = byte_off_i;
      SzHalf:  eff_off[0] = 1'b0;
      SzWord:  eff_off[1:0] = 2'b00;
      default: eff_off = '0;
    endcase
  end

  // Move the addressed field down to bit 0.
  assign shifted = read_data_i >> {eff_off, 3'b000};

  // Sign- or zero-extend the extracted field to the full datapath width.
  always_comb begin
    ext  = shifted;
    fill = 1'b0;
    case (load_size)
      SzByte: begin
        fill = ~load_unsigned_i & shifted[7];
        for (int i = 8; i < DW; i++) ext[i] = fill;
      end
      SzHalf: begin
        fill = ~load_unsigned_i & shifted[15];
        for (int i = 16; i < DW; i++) ext[i] = fill;
      end
      SzWord: begin
        fill = ~load_unsigned_i & shifted[31];
        for (int i = 32; i < DW; i++) ext[i] = fill;
      end
      default: begin
        ext  = read_data_i;
        fill = 1'b0;
      end
    endcase
  end

  // Write-back source select and write-enable qualification (x0 is never written).
  always_comb begin
    rd_nonzero  = (rd_i != '0);
    wb_data_d   = mem_to_reg_i ? ext : alu_res_i;
    reg_write_d = valid_i & reg_write_i & rd_nonzero;
  end

  // Stage register: flush kills the instruction but keeps data, stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      retired_q   <= '0;
    end else if (flush_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= valid_i;
      wb_data_q   <= wb_data_d;
      rd_q        <= rd_i;
      reg_write_q <= reg_write_d;
      if (valid_i) retired_q <= retired_q + 1'b1;
    end
  end

  // Outputs come straight from the stage registers.
  always_comb begin
    valid_o     = valid_q;
    wb_data_o   = wb_data_q;
    rd_o        = rd_q;
    reg_write_o = reg_write_q;
    fwd_en_o    = reg_write_q;
    retired_o   = retired_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors through a scoreboard queue,
// plus hand sequences for flush/stall, counter wrap and asynchronous reset.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_i, flush_i, valid_i;
  logic [31:0]       read_data_i, alu_res_i;
  logic [4:0]        rd_i;
  logic              reg_write_i, mem_to_reg_i;
  logic [1:0]        load_size_i;
  logic              load_unsigned_i;
  logic [1:0]        byte_off_i;
  logic              valid_o;
  logic [31:0]       wb_data_o;
  logic [4:0]        rd_o;
  logic              reg_write_o, fwd_en_o;
  logic [3:0]        retired_o;

  mem_wb_stage #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .valid_i         (valid_i),
    .read_data_i     (read_data_i),
    .alu_res_i       (alu_res_i),
    .rd_i            (rd_i),
    .reg_write_i     (reg_write_i),
    .mem_to_reg_i    (mem_to_reg_i),
    .load_size_i     (load_size_i),
    .load_unsigned_i (load_unsigned_i),
    .byte_off_i      (byte_off_i),
    .valid_o         (valid_o),
    .wb_data_o       (wb_data_o),
    .rd_o            (rd_o),
    .reg_write_o     (reg_write_o),
    .fwd_en_o        (fwd_en_o),
    .retired_o       (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rdata, alu;
    logic [4:0]  rd;
    logic        rw, m2r;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rw, e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw, valid;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic [3:0] cnt;
  int total = 0;
  int bad = 0;
  vec_t tbl[15];

  function automatic vec_t mk(input logic stall, flush, valid, input logic [31:0] rdata, alu,
                              input logic [4:0] rd, input logic rw, m2r,
                              input logic [1:0] size, input logic uns, input logic [1:0] off,
                              input logic [31:0] e_wb, input logic [4:0] e_rd,
                              input logic e_rw, e_valid);
    vec_t v;
    v.stall = stall; v.flush = flush; v.valid = valid; v.rdata = rdata; v.alu = alu;
    v.rd = rd; v.rw = rw; v.m2r = m2r; v.size = size; v.uns = uns; v.off = off;
    v.e_wb = e_wb; v.e_rd = e_rd; v.e_rw = e_rw; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input exp_t e);
    chk({nm, ".valid"}, 64'(valid_o), 64'(e.valid));
    chk({nm, ".wb"}, 64'(wb_data_o), 64'(e.wb));
    chk({nm, ".rd"}, 64'(rd_o), 64'(e.rd));
    chk({nm, ".rw"}, 64'(reg_write_o), 64'(e.rw));
    chk({nm, ".fwd"}, 64'(fwd_en_o), 64'(e.rw));
    chk({nm, ".retired"}, 64'(retired_o), 64'(e.cnt));
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    stall_i = v.stall; flush_i = v.flush; valid_i = v.valid;
    read_data_i = v.rdata; alu_res_i = v.alu; rd_i = v.rd; reg_write_i = v.rw;
    mem_to_reg_i = v.m2r; load_size_i = v.size; load_unsigned_i = v.uns; byte_off_i = v.off;
    if (!v.flush && !v.stall && v.valid) cnt = cnt + 4'd1;
    e.wb = v.e_wb; e.rd = v.e_rd; e.rw = v.e_rw; e.valid = v.e_valid; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk_outs(nm, e);
    last = e;
  endtask

  // Stall/flush vector with new, different inputs; expectation derived from held state.
  function automatic vec_t mk_hold(input logic stall, input logic flush);
    if (flush)
      return mk(stall, flush, 1'b1, 32'h1111_2222, 32'hCAFE_F00D, 5'd29, 1'b1, 1'b0,
                2'b10, 1'b0, 2'b00, last.wb, last.rd, 1'b0, 1'b0);
    return mk(stall, flush, 1'b1, 32'h1111_2222, 32'hCAFE_F00D, 5'd29, 1'b1, 1'b0,
              2'b10, 1'b0, 2'b00, last.wb, last.rd, last.rw, last.valid);
  endfunction

  initial begin
    exp_t z;
    logic saw15, saw_wrap;
    z.wb = '0; z.rd = '0; z.rw = 1'b0; z.valid = 1'b0; z.cnt = '0;
    last = z;
    cnt = '0;
    rst_n = 1'b0;
    stall_i = 0; flush_i = 0; valid_i = 0; read_data_i = '0; alu_res_i = '0; rd_i = '0;
    reg_write_i = 0; mem_to_reg_i = 0; load_size_i = '0; load_unsigned_i = 0; byte_off_i = '0;

    tbl[0]  = mk(0, 0, 1, 32'h0, 32'h1234, 5'd5, 1, 0, 2'b10, 0, 2'd0, 32'h0000_1234, 5'd5, 1, 1);
    tbl[1]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd1, 1, 1, 2'b00, 0, 2'd3,
                 32'hFFFF_FF80, 5'd1, 1, 1);
    tbl[2]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd2, 1, 1, 2'b00, 1, 2'd3,
                 32'h0000_0080, 5'd2, 1, 1);
    tbl[3]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd3, 1, 1, 2'b01, 0, 2'd2,
                 32'hFFFF_80FF, 5'd3, 1, 1);
    tbl[4]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd4, 1, 1, 2'b01, 0, 2'd1,
                 32'h0000_7F01, 5'd4, 1, 1);
    tbl[5]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd6, 1, 1, 2'b10, 0, 2'd0,
                 32'h80FF_7F01, 5'd6, 1, 1);
    tbl[6]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd7, 1, 1, 2'b10, 1, 2'd3,
                 32'h80FF_7F01, 5'd7, 1, 1);
    tbl[7]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd8, 1, 1, 2'b00, 0, 2'd2,
                 32'hFFFF_FFFF, 5'd8, 1, 1);
    tbl[8]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd9, 1, 1, 2'b01, 1, 2'd2,
                 32'h0000_80FF, 5'd9, 1, 1);
    tbl[9]  = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd10, 1, 1, 2'b11, 0, 2'd1,
                 32'h80FF_7F01, 5'd10, 1, 1);
    tbl[10] = mk(0, 0, 1, 32'h80FF7F01, 32'hDEAD, 5'd11, 1, 1, 2'b00, 0, 2'd1,
                 32'h0000_007F, 5'd11, 1, 1);
    tbl[11] = mk(0, 0, 1, 32'h0, 32'h55, 5'd0, 1, 0, 2'b10, 0, 2'd0, 32'h0000_0055, 5'd0, 0, 1);
    tbl[12] = mk(0, 0, 0, 32'h0, 32'h77, 5'd7, 1, 0, 2'b10, 0, 2'd0, 32'h0000_0077, 5'd7, 0, 0);
    tbl[13] = mk(0, 0, 1, 32'h0, 32'hAA, 5'd12, 0, 0, 2'b10, 0, 2'd0, 32'h0000_00AA, 5'd12, 0, 1);
    tbl[14] = mk(0, 0, 0, 32'h80FF7F01, 32'h0, 5'd13, 1, 1, 2'b00, 0, 2'd3,
                 32'hFFFF_FF80, 5'd13, 0, 0);

    #1;
    chk_outs("reset", z);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Flush alone, then stall+flush together, each after a live instruction.
    apply(tbl[0], "pre_flush");
    apply(mk_hold(1'b0, 1'b1), "flush");
    apply(tbl[3], "pre_sf");
    apply(mk_hold(1'b1, 1'b1), "stall_flush");

    // Stall only for three cycles: everything frozen.
    apply(tbl[5], "pre_stall");
    for (int i = 0; i < 3; i++) apply(mk_hold(1'b1, 1'b0), $sformatf("stall%0d", i));
    apply(tbl[4], "post_stall");

    // Sixteen valid instructions must take the 4-bit counter through 15 -> 0.
    saw15 = 1'b0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(mk(0, 0, 1, 32'h0, 32'(i), 5'd3, 1, 0, 2'b10, 0, 2'd0, 32'(i), 5'd3, 1, 1),
            $sformatf("wrap%0d", i));
      if (saw15 && retired_o == 4'd0) saw_wrap = 1'b1;
      saw15 = (retired_o == 4'd15);
    end
    chk("wrap_15_to_0", 64'(saw_wrap), 64'd1);

    // Asynchronous reset mid-cycle with live data held.
    apply(tbl[1], "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset", z);
    @(posedge clk);
    #1;
    chk_outs("reset_held", z);
    cnt = '0;
    last = z;
    rst_n = 1'b1;
    apply(tbl[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
